// File: rtl/ov7670_config_seq.sv
// OV7670 configuration sequencer.
// Walks the register-configuration ROM from address 0 and issues one SCCB
// register write per entry. Entry 0xFFF0 inserts a DELAY_CYCLES wait, entry
// 0xFFFF ends the sequence, and the last ROM address ends it without wrapping.
module ov7670_config_seq #(
  parameter int unsigned DELAY_CYCLES = 250000,
  parameter int unsigned ADDR_W       = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [15:0]       rom_dout,
  output logic              sccb_start,
  output logic [7:0]        sccb_reg,
  output logic [7:0]        sccb_data,
  input  logic              sccb_ready,
  output logic              busy,
  output logic              done
);

  // The delay counter only has to reach DELAY_CYCLES-1.
  localparam int unsigned CNT_W = (DELAY_CYCLES > 1) ? $clog2(DELAY_CYCLES) : 1;
  localparam logic [CNT_W-1:0]  DLY_LAST  = CNT_W'(DELAY_CYCLES - 1);
  localparam logic [ADDR_W-1:0] ADDR_LAST = '1;

  localparam logic [15:0] ENTRY_END   = 16'hFFFF;
  localparam logic [15:0] ENTRY_DELAY = 16'hFFF0;

  typedef enum logic [3:0] {
    IDLE,
    FETCH,
    DECODE,
    SEND,
    WAIT_GUARD,
    WAIT,
    DELAY,
    NEXT,
    FINISH
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] dly_cnt;

  // Sequencer FSM; every output is a register updated here.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      rom_addr   <= '0;
      sccb_start <= 1'b0;
      sccb_reg   <= '0;
      sccb_data  <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      dly_cnt    <= '0;
    end else begin
      sccb_start <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            rom_addr <= '0;
            busy     <= 1'b1;
            done     <= 1'b0;
            state    <= FETCH;
          end
        end

        FETCH: state <= DECODE;

        DECODE: begin
          if (rom_dout == ENTRY_END) begin
            state <= FINISH;
          end else if (rom_dout == ENTRY_DELAY) begin
            dly_cnt <= '0;
            state   <= DELAY;
          end else begin
            sccb_reg  <= rom_dout[15:8];
            sccb_data <= rom_dout[7:0];
            state     <= SEND;
          end
        end

        SEND: begin
          if (sccb_ready) begin
            sccb_start <= 1'b1;
            state      <= WAIT_GUARD;
          end
        end

        // Ready is ignored here so the master has a cycle to drop it.
        WAIT_GUARD: state <= WAIT;

        WAIT: begin
          if (sccb_ready) begin
            state <= NEXT;
          end
        end

        DELAY: begin
          dly_cnt <= dly_cnt + CNT_W'(1);
          if (dly_cnt == DLY_LAST) begin
            state <= NEXT;
          end
        end

        NEXT: begin
          if (rom_addr == ADDR_LAST) begin
            state <= FINISH;
          end else begin
            rom_addr <= rom_addr + ADDR_W'(1);
            state    <= FETCH;
          end
        end

        FINISH: begin
          busy  <= 1'b0;
          done  <= 1'b1;
          state <= IDLE;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule
